// File: rtl/fsm_pkg.sv
// Shared types and helpers for the serial 3-bit ones-counter FSM.
// Latency: pure definitions, no timing of their own.
// Backpressure: none; the counter consumes one bit per clock unconditionally.
//
// Contents:
//   state_t      10 legal states, binary-encoded in 4 bits (6 unused codes)
//   FRAME_LEN    number of serial bits per frame
//   is_legal     true for the 10 defined encodings
//   is_done      true for the absorbing DONE_Cn states
//   pos_of       bits already consumed in the frame (0..3)
//   count_of     ones seen so far (the Moore output of a state)
//   make_state   rebuild a state from (bits consumed, ones seen)
//   next_state   full transition rule, including illegal-code recovery
package fsm_pkg;

  localparam int FRAME_LEN = 3;

  // Name reads as <bits consumed>_<ones seen>. RX0 is "waiting for the
  // first (MSB) bit", DONE is "all three bits taken".
  typedef enum logic [3:0] {
    RX0_C0  = 4'd0,
    RX1_C0  = 4'd1,
    RX1_C1  = 4'd2,
    RX2_C0  = 4'd3,
    RX2_C1  = 4'd4,
    RX2_C2  = 4'd5,
    DONE_C0 = 4'd6,
    DONE_C1 = 4'd7,
    DONE_C2 = 4'd8,
    DONE_C3 = 4'd9
  } state_t;

  function automatic logic is_legal(input state_t s);
    logic ok;
    ok = 1'b0;
    case (s)
      RX0_C0, RX1_C0, RX1_C1, RX2_C0, RX2_C1, RX2_C2,
      DONE_C0, DONE_C1, DONE_C2, DONE_C3: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_done(input state_t s);
    logic d;
    d = 1'b0;
    case (s)
      DONE_C0, DONE_C1, DONE_C2, DONE_C3: d = 1'b1;
      default: d = 1'b0;
    endcase
    return d;
  endfunction

  // Bits consumed so far; 3 means the frame is complete.
  // Unused codes report 0 so they look like a fresh frame.
  function automatic logic [1:0] pos_of(input state_t s);
    logic [1:0] p;
    p = 2'd0;
    case (s)
      RX0_C0:                              p = 2'd0;
      RX1_C0, RX1_C1:                      p = 2'd1;
      RX2_C0, RX2_C1, RX2_C2:              p = 2'd2;
      DONE_C0, DONE_C1, DONE_C2, DONE_C3:  p = 2'd3;
      default:                             p = 2'd0;
    endcase
    return p;
  endfunction

  // Ones seen so far. Unused codes decode to 0 so out never shows junk.
  function automatic logic [1:0] count_of(input state_t s);
    logic [1:0] c;
    c = 2'd0;
    case (s)
      RX0_C0, RX1_C0, RX2_C0, DONE_C0: c = 2'd0;
      RX1_C1, RX2_C1, DONE_C1:         c = 2'd1;
      RX2_C2, DONE_C2:                 c = 2'd2;
      DONE_C3:                         c = 2'd3;
      default:                         c = 2'd0;
    endcase
    return c;
  endfunction

  // Inverse of (pos_of, count_of). A count larger than the position is
  // unreachable; it falls back to the idle state rather than guessing.
  function automatic state_t make_state(input logic [1:0] pos,
                                        input logic [1:0] cnt);
    state_t s;
    s = RX0_C0;
    case ({pos, cnt})
      {2'd0, 2'd0}: s = RX0_C0;
      {2'd1, 2'd0}: s = RX1_C0;
      {2'd1, 2'd1}: s = RX1_C1;
      {2'd2, 2'd0}: s = RX2_C0;
      {2'd2, 2'd1}: s = RX2_C1;
      {2'd2, 2'd2}: s = RX2_C2;
      {2'd3, 2'd0}: s = DONE_C0;
      {2'd3, 2'd1}: s = DONE_C1;
      {2'd3, 2'd2}: s = DONE_C2;
      {2'd3, 2'd3}: s = DONE_C3;
      default:      s = RX0_C0;
    endcase
    return s;
  endfunction

  // One step of the frame: consume a bit unless the frame is already
  // complete (DONE is absorbing). Unused codes restart the frame.
  // Neither sum can overflow 2 bits: pos <= 2 and cnt <= pos here.
  function automatic state_t next_state(input state_t s, input logic b);
    state_t n;
    if (!is_legal(s)) begin
      n = RX0_C0;
    end else if (is_done(s)) begin
      n = s;
    end else begin
      n = make_state(pos_of(s) + 2'd1, count_of(s) + {1'b0, b});
    end
    return n;
  endfunction

endpackage

// File: rtl/fsm.sv
// Serial 3-bit frame ones counter: counts 1s on the next three bits after reset.
// Latency: a bit sampled at edge k is reflected on out right after edge k.
// Backpressure: none; one bit is consumed per clock until the frame is done,
//   after which in is ignored and out holds until the next reset.
//
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous reset, active-low
//   in   in   serial data bit, MSB first
//   out  out  [1:0] ones seen in the current frame, registered
module fsm
  import fsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  output logic [1:0] out
);

  state_t state;
  state_t state_nxt;

  assign state_nxt = next_state(state, in);

  // out is loaded from the decode of the state being entered, so it always
  // equals count_of(state) without a combinational path from in.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RX0_C0;
      out   <= 2'd0;
    end else begin
      state <= state_nxt;
      out   <= count_of(state_nxt);
    end
  end

endmodule

// File: tb/tb_fsm.sv
module tb_fsm;

  logic       clk;
  logic       rst;
  logic       in;
  logic [1:0] out;

  int checks   = 0;
  int failures = 0;

  // Reference: number of bits taken and ones seen in the current frame.
  int m_seen = 0;
  int m_cnt  = 0;

  fsm dut (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag);
    logic [1:0] exp;
    exp = m_cnt[1:0];
    checks++;
    assert (out === exp) else begin
      failures++;
      $error("FAIL %s: out=%0d expected=%0d", tag, out, exp);
    end
  endtask

  // Drive inputs, take one rising edge, advance the model, check 1 time unit later.
  task automatic step(input logic r, input logic b, input string tag);
    rst = r;
    in  = b;
    @(posedge clk);
    if (!r) begin
      m_seen = 0;
      m_cnt  = 0;
    end else if (m_seen < 3) begin
      m_seen = m_seen + 1;
      m_cnt  = m_cnt + int'(b);
    end
    #1;
    check(tag);
  endtask

  initial begin
    logic [2:0] jv;
    rst = 1'b0;
    in  = 1'b0;

    // Reset, then all-zero frame and a hold edge.
    step(0, 1, "reset");
    step(1, 0, "f000_b2");
    step(1, 0, "f000_b1");
    step(1, 0, "f000_b0");
    step(1, 1, "f000_hold");

    // Frame 1,0,1 then hold with in=1.
    step(0, 0, "reset2");
    step(1, 1, "f101_b2");
    step(1, 0, "f101_b1");
    step(1, 1, "f101_b0");
    step(1, 1, "f101_hold");

    // Frame 1,1,1 held for 5 edges with in toggling.
    step(0, 0, "reset3");
    step(1, 1, "f111_b2");
    step(1, 1, "f111_b1");
    step(1, 1, "f111_b0");
    for (int i = 0; i < 5; i++) step(1, logic'(i % 2), "f111_hold");

    // Reset mid-frame discards the partial count.
    step(0, 0, "reset4");
    step(1, 0, "f011_b2");
    step(1, 1, "f011_b1");
    step(0, 1, "midframe_reset");
    step(1, 1, "f110_b2");
    step(1, 1, "f110_b1");
    step(1, 0, "f110_b0");

    // rst low without an edge must not change out.
    rst = 1'b0;
    in  = 1'b1;
    #3;
    check("rst_no_edge");
    step(0, 1, "rst_first_edge");

    // All 8 frames, reset between each.
    for (int j = 0; j < 8; j++) begin
      jv = 3'(j);
      step(0, 0, "sweep_rst");
      for (int k = 2; k >= 0; k--) step(1, jv[k], "sweep_bit");
      check("sweep_final");
      step(1, ~jv[0], "sweep_hold");
    end

    // Random bits with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(logic'($urandom_range(0, 7) != 0), logic'($urandom & 1), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
